// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I processor with internal instruction
// memory, data memory, register file and a memory-mapped LED register.
package rv32i_core_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;
    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
    typedef enum logic {OP2_RS2, OP2_IMM} op2_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_UIMM} wb_sel_e;
endpackage

module rv32i_imem #(
    parameter int WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(WORDS)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [31:0]              addr_in,
    output logic [31:0]              data_out
);
    localparam int AW = $clog2(WORDS);
    logic [31:0] mem [WORDS];
    logic        unused_addr;

    // write port reserved for a loader; the core ties it off
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign data_out    = mem[addr_in[AW+1:2]];
    assign unused_addr = ^{addr_in[31:AW+2], addr_in[1:0]};
endmodule

module rv32i_dmem #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic [31:0] addr_in,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic [2:0]  fn3,
    output logic [31:0] data_out
);
    localparam int AW = $clog2(WORDS);
    logic [31:0]   mem [WORDS];
    logic [31:0]   _addr_in;
    logic [31:0]   rdata;
    logic [AW-1:0] w0, w1;
    logic [1:0]    off;
    logic [63:0]   pair, wd64;
    logic [7:0]    be8;
    logic [3:0]    be4;
    logic          unused_dm;

    assign _addr_in  = {addr_in[31:2], 2'b00};
    assign off       = addr_in[1:0];
    assign w0        = _addr_in[AW+1:2];
    assign w1        = w0 + AW'(1);
    assign unused_dm = ^{_addr_in[31:AW+2], _addr_in[1:0]};

    // two adjacent words cover any misaligned access
    assign pair  = {mem[w1], mem[w0]};
    assign rdata = 32'(pair >> {off, 3'b000});

    always_comb begin
        case (fn3)
            3'b000:  data_out = {{24{rdata[7]}}, rdata[7:0]};
            3'b001:  data_out = {{16{rdata[15]}}, rdata[15:0]};
            3'b100:  data_out = {24'b0, rdata[7:0]};
            3'b101:  data_out = {16'b0, rdata[15:0]};
            default: data_out = rdata;
        endcase
    end

    always_comb begin
        case (fn3[1:0])
            2'b00:   be4 = 4'b0001;
            2'b01:   be4 = 4'b0011;
            default: be4 = 4'b1111;
        endcase
    end

    assign be8  = {4'b0, be4} << off;
    assign wd64 = {32'b0, wr_data} << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be8[k])
                    mem[w0][8*k +: 8] <= wd64[8*k +: 8];
                if (be8[k+4])
                    mem[w1][8*k +: 8] <= wd64[32+8*k +: 8];
            end
        end
    end
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    input  logic [4:0]  wsel,
    input  logic [31:0] wdata,
    input  logic        wen,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (wen && wsel != 5'd0) begin
            registers[wsel] <= wdata;
        end
    end

    assign rdata1 = (rsel1 == 5'd0) ? '0 : registers[rsel1];
    assign rdata2 = (rsel2 == 5'd0) ? '0 : registers[rsel2];
endmodule

module rv32i_cu
    import rv32i_core_pkg::*;
(
    input  logic [31:0] instr,
    output logic        RF_wen,
    output logic        mem_wen,
    output alu_op_e     alu_op,
    output op1_sel_e    op1_sel,
    output op2_sel_e    op2_sel,
    output wb_sel_e     wb_sel,
    output logic [31:0] imm,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        is_lui, is_auipc, is_load, is_store, is_opi, is_op;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign is_lui    = opc == 7'b0110111;
    assign is_auipc  = opc == 7'b0010111;
    assign is_jal    = opc == 7'b1101111;
    assign is_jalr   = opc == 7'b1100111;
    assign is_branch = opc == 7'b1100011;
    assign is_load   = opc == 7'b0000011;
    assign is_store  = opc == 7'b0100011;
    assign is_opi    = opc == 7'b0010011;
    assign is_op     = opc == 7'b0110011;

    function automatic alu_op_e alu_dec(input logic [2:0] fn,
                                        input logic alt);
        alu_op_e r;
        case (fn)
            3'd0:    r = alt ? ALU_SUB : ALU_ADD;
            3'd1:    r = ALU_SLL;
            3'd2:    r = ALU_SLT;
            3'd3:    r = ALU_SLTU;
            3'd4:    r = ALU_XOR;
            3'd5:    r = alt ? ALU_SRA : ALU_SRL;
            3'd6:    r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        RF_wen  = 1'b0;
        mem_wen = 1'b0;
        alu_op  = ALU_ADD;
        op1_sel = OP1_RS1;
        op2_sel = OP2_IMM;
        wb_sel  = WB_ALU;
        imm     = '0;
        unique case (1'b1)
            is_lui: begin
                RF_wen  = 1'b1;
                op1_sel = OP1_ZERO;
                wb_sel  = WB_UIMM;
                imm     = imm_u;
            end
            is_auipc: begin
                RF_wen  = 1'b1;
                op1_sel = OP1_PC;
                imm     = imm_u;
            end
            is_jal: begin
                RF_wen = 1'b1;
                wb_sel = WB_PC4;
                imm    = imm_j;
            end
            is_jalr: begin
                RF_wen = 1'b1;
                wb_sel = WB_PC4;
                imm    = imm_i;
            end
            is_branch: begin
                op2_sel = OP2_RS2;
                imm     = imm_b;
            end
            is_load: begin
                RF_wen = 1'b1;
                wb_sel = WB_MEM;
                imm    = imm_i;
            end
            is_store: begin
                mem_wen = 1'b1;
                imm     = imm_s;
            end
            is_opi: begin
                RF_wen = 1'b1;
                alu_op = alu_dec(f3, f3 == 3'd5 && instr[30]);
                imm    = imm_i;
            end
            is_op: begin
                RF_wen  = 1'b1;
                op2_sel = OP2_RS2;
                alu_op  = alu_dec(f3, instr[30]);
            end
            default: ;
        endcase
    end
endmodule

module rv32i_core
    import rv32i_core_pkg::*;
#(
    parameter int          IMEM_WORDS = 4096,
    parameter int          DMEM_WORDS = 4096,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] LED_ADDR   = 32'hFFFF_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] leds,
    input  logic       btn,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    logic [31:0] pc_q, pc_d;
    logic [5:0]  leds_q, leds_d;
    logic [31:0] program_counter, instruction, pc_plus4, target;
    logic        branch_taken, cond;
    logic [4:0]  RF_rsel1, RF_rsel2, RF_wsel;
    logic [31:0] RF_rdata1, RF_rdata2, RF_wdata;
    logic        RF_wen, mem_wen, DM_wen, is_led;
    logic        is_branch, is_jal, is_jalr;
    wb_sel_e     RF_wdata_sel;
    op1_sel_e    ALU_OP1_SEL;
    op2_sel_e    ALU_OP2_SEL;
    alu_op_e     alu_op;
    logic [31:0] ALU_A, ALU_B, ALU_OUT, Immediate_imm;
    logic [31:0] DM_OUT, dm_rdata;
    logic [2:0]  fn3;
    logic        unused_pins;

    assign program_counter = pc_q;
    assign leds            = leds_q;
    assign uart_tx         = 1'b1;
    assign unused_pins     = btn ^ uart_rx;

    rv32i_imem #(.WORDS(IMEM_WORDS)) im (
        .clk     (clk),
        .wr_en   (1'b0),
        .wr_addr ('0),
        .wr_data ('0),
        .addr_in (pc_q),
        .data_out(instruction)
    );

    rv32i_cu cu (
        .instr    (instruction),
        .RF_wen   (RF_wen),
        .mem_wen  (mem_wen),
        .alu_op   (alu_op),
        .op1_sel  (ALU_OP1_SEL),
        .op2_sel  (ALU_OP2_SEL),
        .wb_sel   (RF_wdata_sel),
        .imm      (Immediate_imm),
        .is_branch(is_branch),
        .is_jal   (is_jal),
        .is_jalr  (is_jalr)
    );

    assign RF_rsel1 = instruction[19:15];
    assign RF_rsel2 = instruction[24:20];
    assign RF_wsel  = instruction[11:7];
    assign fn3      = instruction[14:12];

    rv32i_regfile rf (
        .clk   (clk),
        .rst_n (rst_n),
        .rsel1 (RF_rsel1),
        .rsel2 (RF_rsel2),
        .wsel  (RF_wsel),
        .wdata (RF_wdata),
        .wen   (RF_wen),
        .rdata1(RF_rdata1),
        .rdata2(RF_rdata2)
    );

    always_comb begin
        case (ALU_OP1_SEL)
            OP1_RS1: ALU_A = RF_rdata1;
            OP1_PC:  ALU_A = pc_q;
            default: ALU_A = '0;
        endcase
    end
    assign ALU_B = (ALU_OP2_SEL == OP2_RS2) ? RF_rdata2 : Immediate_imm;

    always_comb begin
        case (alu_op)
            ALU_SUB:  ALU_OUT = ALU_A - ALU_B;
            ALU_SLL:  ALU_OUT = ALU_A << ALU_B[4:0];
            ALU_SLT:  ALU_OUT = {31'b0, $signed(ALU_A) < $signed(ALU_B)};
            ALU_SLTU: ALU_OUT = {31'b0, ALU_A < ALU_B};
            ALU_XOR:  ALU_OUT = ALU_A ^ ALU_B;
            ALU_SRL:  ALU_OUT = ALU_A >> ALU_B[4:0];
            ALU_SRA:  ALU_OUT = $signed(ALU_A) >>> ALU_B[4:0];
            ALU_OR:   ALU_OUT = ALU_A | ALU_B;
            ALU_AND:  ALU_OUT = ALU_A & ALU_B;
            default:  ALU_OUT = ALU_A + ALU_B;
        endcase
    end

    // the LED register shadows its address; memory is never touched there
    assign is_led = ALU_OUT == LED_ADDR;
    assign DM_wen = mem_wen && !is_led;

    rv32i_dmem #(.WORDS(DMEM_WORDS)) dm (
        .clk     (clk),
        .addr_in (ALU_OUT),
        .wr_data (RF_rdata2),
        .wr_en   (DM_wen),
        .fn3     (fn3),
        .data_out(dm_rdata)
    );

    assign DM_OUT = is_led ? {26'b0, leds_q} : dm_rdata;
    assign leds_d = (mem_wen && is_led) ? RF_rdata2[5:0] : leds_q;

    always_comb begin
        case (fn3)
            3'b000:  cond = RF_rdata1 == RF_rdata2;
            3'b001:  cond = RF_rdata1 != RF_rdata2;
            3'b100:  cond = $signed(RF_rdata1) < $signed(RF_rdata2);
            3'b101:  cond = $signed(RF_rdata1) >= $signed(RF_rdata2);
            3'b110:  cond = RF_rdata1 < RF_rdata2;
            3'b111:  cond = RF_rdata1 >= RF_rdata2;
            default: cond = 1'b0;
        endcase
    end

    assign pc_plus4     = pc_q + 32'd4;
    assign branch_taken = is_jal || is_jalr || (is_branch && cond);
    assign target       = is_jalr ? (ALU_OUT & ~32'd1)
                                  : pc_q + Immediate_imm;
    assign pc_d         = (branch_taken ? target : pc_plus4) & PC_MASK;

    always_comb begin
        case (RF_wdata_sel)
            WB_MEM:  RF_wdata = DM_OUT;
            WB_PC4:  RF_wdata = pc_plus4;
            WB_UIMM: RF_wdata = Immediate_imm;
            default: RF_wdata = ALU_OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            leds_q <= '0;
        end else begin
            pc_q   <= pc_d;
            leds_q <= leds_d;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed and random programs, each retired
// instruction scored against an instruction-level model.
`timescale 1ns/1ps
module tb_rv32i_core;
    localparam int          IMW   = 4096;
    localparam int          DMW   = 4096;
    localparam logic [31:0] LED_A = 32'hFFFF_0000;
    localparam logic [31:0] HALT  = 32'h0000_006F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [5:0] leds;

    rv32i_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .leds   (leds),
        .btn    (btn),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [5:0]  leds;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] prog[$];
    logic [31:0] m_regs[32];
    logic [7:0]  m_mem[int];
    logic [31:0] m_pc;
    logic [5:0]  m_leds;
    int          checks = 0;
    int          errors = 0;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h",
                     name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            check("pc", dut.program_counter, e.pc);
            check($sformatf("x%0d", e.rd),
                  dut.rf.registers[e.rd], e.val);
            check("leds", {26'b0, leds}, {26'b0, e.leds});
        end
    end

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                          int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                          int rd, logic [6:0] op);
        logic [11:0] i12 = 12'(imm);
        return {i12, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1,
                                          int f3);
        logic [11:0] i12 = 12'(imm);
        return {i12[11:5], 5'(rs2), 5'(rs1), 3'(f3),
                i12[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1,
                                          int f3);
        logic [12:0] i13 = 13'(imm);
        return {i13[12], i13[10:5], 5'(rs2), 5'(rs1), 3'(f3),
                i13[4:1], i13[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd,
                                          logic [6:0] op);
        return {20'(imm20), 5'(rd), op};
    endfunction

    function automatic int bidx(logic [31:0] a);
        return int'(a % 32'(DMW * 4));
    endfunction

    function automatic logic [7:0] rdb(logic [31:0] a);
        int i = bidx(a);
        return m_mem.exists(i) ? m_mem[i] : 8'h00;
    endfunction

    function automatic logic [31:0] m_alu(logic [2:0] f3, logic alt,
                                          logic [31:0] a,
                                          logic [31:0] b);
        int sh = int'(b[4:0]);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_taken(logic [2:0] f3, logic [31:0] a,
                                     logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] ins, a, b, res, nxt, ea, w;
        logic [31:0] immi, imms, immb, immu, immj;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wr;
        int          idx, n;
        exp_t        e;
        idx  = int'((m_pc >> 2) % IMW);
        ins  = (idx < prog.size()) ? prog[idx] : HALT;
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        rd   = ins[11:7];
        f3   = ins[14:12];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                ins[11:8], 1'b0};
        immu = {ins[31:12], 12'b0};
        immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                ins[30:21], 1'b0};
        nxt  = m_pc + 4;
        wr   = 1'b0;
        res  = '0;
        case (ins[6:0])
            7'h37: begin wr = 1; res = immu; end
            7'h17: begin wr = 1; res = m_pc + immu; end
            7'h6F: begin wr = 1; res = m_pc + 4; nxt = m_pc + immj; end
            7'h67: begin
                wr = 1; res = m_pc + 4; nxt = (a + immi) & ~32'h1;
            end
            7'h63: if (m_taken(f3, a, b)) nxt = m_pc + immb;
            7'h03: begin
                wr = 1;
                ea = a + immi;
                w  = {rdb(ea + 3), rdb(ea + 2), rdb(ea + 1), rdb(ea)};
                if (ea == LED_A) w = {26'b0, m_leds};
                case (f3)
                    3'd0: res = {{24{w[7]}}, w[7:0]};
                    3'd1: res = {{16{w[15]}}, w[15:0]};
                    3'd4: res = {24'b0, w[7:0]};
                    3'd5: res = {16'b0, w[15:0]};
                    default: res = w;
                endcase
            end
            7'h23: begin
                ea = a + imms;
                n  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                if (ea == LED_A) m_leds = b[5:0];
                else
                    for (int i = 0; i < n; i++)
                        m_mem[bidx(ea + 32'(i))] = b[8*i +: 8];
            end
            7'h13: begin
                wr  = 1;
                res = m_alu(f3, f3 == 3'd5 && ins[30], a, immi);
            end
            7'h33: begin wr = 1; res = m_alu(f3, ins[30], a, b); end
            default: ;
        endcase
        if (wr && rd != 0) m_regs[rd] = res;
        m_pc   = nxt & 32'(IMW * 4 - 1);
        e.pc   = m_pc;
        e.rd   = wr ? rd : 5'd0;
        e.val  = m_regs[e.rd];
        e.leds = m_leds;
        sbq.push_back(e);
    endtask

    task automatic run_prog(int steps);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < IMW; i++)
            dut.im.mem[i] = (i < prog.size()) ? prog[i] : HALT;
        m_pc   = '0;
        m_leds = '0;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        for (int s = 0; s < steps; s++) model_step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < steps + 50 && sbq.size() > 0; c++)
            @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d entries left, want 0",
                     sbq.size());
            sbq.delete();
        end
    endtask

    task automatic gen_random(int n);
        int lf3[5] = '{0, 1, 2, 4, 5};
        int bf3[6] = '{0, 1, 4, 5, 6, 7};
        int rd, rs1, rs2, f3, imm, kind;
        prog.delete();
        for (int r = 1; r < 16; r++) begin
            prog.push_back(enc_u(int'($urandom), r, 7'h37));
            prog.push_back(enc_i(int'($urandom), r, 0, r, 7'h13));
        end
        for (int k = 0; k < 8; k++)
            prog.push_back(enc_s(32'h200 + 4 * k, k + 1, 0, 2));
        for (int j = 0; j < n; j++) begin
            kind = $urandom_range(0, 9);
            rd   = $urandom_range(0, 31);
            rs1  = $urandom_range(0, 31);
            rs2  = $urandom_range(0, 31);
            f3   = $urandom_range(0, 7);
            case (kind)
                0, 1: prog.push_back(enc_r(
                    ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1)
                        ? 32 : 0, rs2, rs1, f3, rd));
                2, 3: begin
                    imm = int'($urandom);
                    if (f3 == 1) imm = $urandom_range(0, 31);
                    if (f3 == 5)
                        imm = $urandom_range(0, 31)
                            + ($urandom_range(0, 1) == 1 ? 32'h400 : 0);
                    prog.push_back(enc_i(imm, rs1, f3, rd, 7'h13));
                end
                4: prog.push_back(enc_u(int'($urandom), rd,
                    $urandom_range(0, 1) == 1 ? 7'h37 : 7'h17));
                5, 6: prog.push_back(enc_i(
                    32'h200 + $urandom_range(0, 28), 0,
                    lf3[$urandom_range(0, 4)], rd, 7'h03));
                7: prog.push_back(enc_s(
                    32'h200 + $urandom_range(0, 28), rs2, 0,
                    $urandom_range(0, 2)));
                8: prog.push_back(enc_b(4 * $urandom_range(2, 4),
                    rs2, rs1, bf3[$urandom_range(0, 5)]));
                default: prog.push_back(
                    $urandom_range(0, 1) == 1 ? 32'h0000000F
                                              : 32'h00000073);
            endcase
        end
        repeat (8) prog.push_back(HALT);
    endtask

    initial begin
        #2;
        check("reset pc", dut.program_counter, 32'h0);
        check("reset leds", {26'b0, leds}, 32'h0);
        check("uart_tx", {31'b0, uart_tx}, 32'h1);
        check("reset x1", dut.rf.registers[1], 32'h0);

        prog.delete();
        repeat (128) prog.push_back(HALT);
        prog[0]  = enc_i(5, 0, 0, 1, 7'h13);
        prog[1]  = enc_i(-7, 1, 0, 2, 7'h13);
        prog[2]  = enc_s(0, 2, 0, 2);
        prog[3]  = enc_i(0, 0, 0, 3, 7'h03);
        prog[4]  = enc_i(1, 0, 4, 4, 7'h03);
        prog[5]  = enc_b(12, 0, 1, 1);
        prog[6]  = enc_i(99, 0, 0, 9, 7'h13);
        prog[7]  = enc_i(99, 0, 0, 9, 7'h13);
        prog[8]  = enc_b(12, 0, 8, 1);
        prog[9]  = enc_i(32'h101, 0, 0, 6, 7'h13);
        prog[10] = enc_i(8, 6, 0, 5, 7'h67);
        prog[66] = enc_i(1, 0, 0, 0, 7'h13);
        prog[67] = enc_u(32'h80000, 20, 7'h37);
        prog[68] = enc_i(31, 0, 0, 21, 7'h13);
        prog[69] = enc_r(32, 21, 20, 5, 22);
        prog[70] = enc_i(1, 0, 0, 23, 7'h13);
        prog[71] = enc_i(-1, 0, 0, 24, 7'h13);
        prog[72] = enc_r(0, 24, 23, 3, 25);
        prog[73] = enc_r(32, 23, 0, 0, 26);
        prog[74] = enc_u(32'hFFFF0, 10, 7'h37);
        prog[75] = enc_i(32'h2A, 0, 0, 11, 7'h13);
        prog[76] = enc_s(0, 11, 10, 2);
        prog[77] = enc_i(0, 10, 2, 12, 7'h03);
        run_prog(26);

        check("addi x1", dut.rf.registers[1], 32'h5);
        check("addi x2", dut.rf.registers[2], 32'hFFFFFFFE);
        check("sw mem0", dut.dm.mem[0], 32'hFFFFFFFE);
        check("lb x3", dut.rf.registers[3], 32'hFFFFFFFE);
        check("lbu x4", dut.rf.registers[4], 32'h000000FF);
        check("skipped x9", dut.rf.registers[9], 32'h0);
        check("jalr x5", dut.rf.registers[5], 32'h2C);
        check("x0", dut.rf.registers[0], 32'h0);
        check("sra", dut.rf.registers[22], 32'hFFFFFFFF);
        check("sltu", dut.rf.registers[25], 32'h1);
        check("sub", dut.rf.registers[26], 32'hFFFFFFFF);
        check("led load", dut.rf.registers[12], 32'h2A);
        check("halt pc", dut.program_counter, 32'h138);
        check("leds set", {26'b0, leds}, 32'h2A);

        #2 rst_n = 1'b0;
        #1;
        check("async pc", dut.program_counter, 32'h0);
        check("async leds", {26'b0, leds}, 32'h0);
        check("async x1", dut.rf.registers[1], 32'h0);

        for (int t = 0; t < 4; t++) begin
            gen_random(80);
            run_prog(prog.size() + 5);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
